// File: rtl/elim_pkg.sv
// Shared state encoding and result codes for the elimination controller.
package elim_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_TIMEOUT  = 2'b01,
    ST_ALL_ZERO = 2'b10
  } status_t;

endpackage

// File: rtl/elim_controller_if.sv
// Bundle of the controller's run-request, PU flag and result signals.
interface elim_controller_if;
  import elim_pkg::*;

  logic       start;
  logic       end_signal;
  logic       PU0_zero;
  logic       PU1_zero;
  logic       PU2_zero;
  logic       PU3_zero;
  logic       PU_load;
  logic       PU_en;
  logic       done;
  logic [1:0] winner;
  logic [1:0] status;
  logic [7:0] iter_count;

  // master drives requests and PU flags; slave is the controller side
  modport master (
    output start, end_signal, PU0_zero, PU1_zero, PU2_zero, PU3_zero,
    input  PU_load, PU_en, done, winner, status, iter_count
  );

  modport slave (
    input  start, end_signal, PU0_zero, PU1_zero, PU2_zero, PU3_zero,
    output PU_load, PU_en, done, winner, status, iter_count
  );

endinterface

// File: rtl/zero_encoder.sv
// Maps four per-PU zero flags to the index of the single nonzero PU (00 otherwise).
module zero_encoder
  import elim_pkg::*;
(
  input  logic [3:0] zero,
  output logic [1:0] index
);

  always_comb begin
    index = '0;
    case (zero)
      4'b1110: index = 2'd0;
      4'b1101: index = 2'd1;
      4'b1011: index = 2'd2;
      4'b0111: index = 2'd3;
      default: index = '0;
    endcase
  end

endmodule

// File: rtl/elim_controller.sv
// Load/run/done sequencer for four processing units with end, all-zero and
// iteration-limit exits; results hold until the next run is loaded.
module elim_controller
  import elim_pkg::*;
#(
  parameter int unsigned MAX_ITER = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       end_signal,
  input  logic       PU0_zero,
  input  logic       PU1_zero,
  input  logic       PU2_zero,
  input  logic       PU3_zero,
  output logic       PU_load,
  output logic       PU_en,
  output logic       done,
  output logic [1:0] winner,
  output logic [1:0] status,
  output logic [7:0] iter_count
);

  localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);

  state_t     state;
  status_t    status_q;
  logic [3:0] zero_flags;
  logic [1:0] enc_index;
  logic       all_zero;

  assign zero_flags = {PU3_zero, PU2_zero, PU1_zero, PU0_zero};
  assign all_zero   = &zero_flags;
  assign status     = status_q;

  zero_encoder u_zero_encoder (
    .zero  (zero_flags),
    .index (enc_index)
  );

  // Outputs are registered on the transition into each state so they
  // line up exactly with the state register (Moore behaviour).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      PU_load    <= 1'b0;
      PU_en      <= 1'b0;
      done       <= 1'b0;
      winner     <= '0;
      status_q   <= ST_OK;
      iter_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD;
            PU_load    <= 1'b1;
            winner     <= '0;
            status_q   <= ST_OK;
            iter_count <= '0;
          end
        end
        S_LOAD: begin
          state   <= S_RUN;
          PU_load <= 1'b0;
          PU_en   <= 1'b1;
        end
        S_RUN: begin
          // exit priority: end_signal, then all-zero, then iteration limit
          if (end_signal) begin
            state    <= S_DONE;
            PU_en    <= 1'b0;
            done     <= 1'b1;
            status_q <= ST_OK;
            winner   <= enc_index;
          end else if (all_zero) begin
            state    <= S_DONE;
            PU_en    <= 1'b0;
            done     <= 1'b1;
            status_q <= ST_ALL_ZERO;
            winner   <= '0;
          end else if (iter_count == ITER_LIMIT) begin
            state    <= S_DONE;
            PU_en    <= 1'b0;
            done     <= 1'b1;
            status_q <= ST_TIMEOUT;
            winner   <= '0;
          end else if (iter_count < ITER_LIMIT) begin
            iter_count <= iter_count + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          PU_load <= 1'b0;
          PU_en   <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elim_controller.sv
// Directed bench for elim_controller: a run-level model predicts each run's
// outcome and a per-cycle compare process checks every output.
module tb_elim_controller;

  localparam int unsigned MAXI = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elim_controller_if bus ();

  elim_controller #(.MAX_ITER(MAXI)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (bus.start),
    .end_signal (bus.end_signal),
    .PU0_zero   (bus.PU0_zero),
    .PU1_zero   (bus.PU1_zero),
    .PU2_zero   (bus.PU2_zero),
    .PU3_zero   (bus.PU3_zero),
    .PU_load    (bus.PU_load),
    .PU_en      (bus.PU_en),
    .done       (bus.done),
    .winner     (bus.winner),
    .status     (bus.status),
    .iter_count (bus.iter_count)
  );

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  logic       exp_load, exp_en, exp_done;
  logic [1:0] exp_winner, exp_status;
  logic [7:0] exp_iter;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("PU_load",    32'(bus.PU_load),    32'(exp_load));
      check("PU_en",      32'(bus.PU_en),      32'(exp_en));
      check("done",       32'(bus.done),       32'(exp_done));
      check("winner",     32'(bus.winner),     32'(exp_winner));
      check("status",     32'(bus.status),     32'(exp_status));
      check("iter_count", 32'(bus.iter_count), 32'(exp_iter));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic es, input logic [3:0] f);
    bus.end_signal = es;
    {bus.PU3_zero, bus.PU2_zero, bus.PU1_zero, bus.PU0_zero} = f;
  endtask

  function automatic logic [1:0] sole_nonzero(input logic [3:0] z);
    int nz = 0;
    logic [1:0] idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!z[i]) begin
        nz++;
        idx = 2'(i);
      end
    return (nz == 1) ? idx : 2'd0;
  endfunction

  task automatic clear_exp();
    exp_load = 1'b0; exp_en = 1'b0; exp_done = 1'b0;
    exp_winner = 2'd0; exp_status = 2'd0; exp_iter = 8'd0;
  endtask

  // RUN cycle j sees quiet stimulus before n_quiet, final stimulus from then on.
  task automatic run_case(input int n_quiet, input logic [3:0] quiet_f,
                          input logic fin_es, input logic [3:0] fin_f,
                          input int rst_at, input bit hold_start);
    int ex = -1;
    logic [1:0] m_win = 2'd0;
    logic [1:0] m_st  = 2'd0;
    logic es;
    logic [3:0] f;
    for (int j = 0; j <= int'(MAXI); j++) begin
      es = (j >= n_quiet) ? fin_es : 1'b0;
      f  = (j >= n_quiet) ? fin_f  : quiet_f;
      if (es) begin
        ex = j; m_st = 2'b00; m_win = sole_nonzero(f); break;
      end else if (f == 4'hF) begin
        ex = j; m_st = 2'b10; m_win = 2'd0; break;
      end else if (j == int'(MAXI)) begin
        ex = j; m_st = 2'b01; m_win = 2'd0; break;
      end
    end

    bus.start = 1'b1;
    tick();
    if (!hold_start) bus.start = 1'b0;
    clear_exp();
    exp_load = 1'b1;
    set_flags(1'b1, 4'hF);
    tick();

    for (int j = 0; j <= ex; j++) begin
      exp_load = 1'b0;
      exp_en   = 1'b1;
      exp_iter = 8'(j);
      if (j == rst_at) begin
        set_flags(1'b1, 4'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        set_flags(1'b0, 4'b0000);
        clear_exp();
        return;
      end
      set_flags((j >= n_quiet) ? fin_es : 1'b0, (j >= n_quiet) ? fin_f : quiet_f);
      tick();
    end

    exp_en = 1'b0; exp_done = 1'b1;
    exp_winner = m_win; exp_status = m_st; exp_iter = 8'(ex);
    set_flags(1'b1, 4'b1110);
    tick();
    exp_done = 1'b0;
    bus.start = 1'b0;
    set_flags(1'b0, 4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b1;
    set_flags(1'b1, 4'hF);
    clear_exp();
    tick();
    checking = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    set_flags(1'b0, 4'b0000);

    // normal: PU0 sole survivor after 5 RUN cycles
    run_case(5, 4'b1100, 1'b1, 4'b1110, -1, 1'b0);
    check("lit_normal_iter",   32'(bus.iter_count), 32'd5);
    check("lit_normal_winner", 32'(bus.winner),     32'd0);
    check("lit_normal_status", 32'(bus.status),     32'd0);
    tick();

    // PU2 sole survivor
    run_case(2, 4'b0011, 1'b1, 4'b1011, -1, 1'b0);
    check("lit_win2_winner", 32'(bus.winner), 32'd2);
    check("lit_win2_status", 32'(bus.status), 32'd0);

    // timeout with mixed flags
    run_case(100, 4'b0101, 1'b0, 4'b0101, -1, 1'b0);
    check("lit_timeout_iter",   32'(bus.iter_count), 32'd10);
    check("lit_timeout_status", 32'(bus.status),     32'd1);

    // all PUs reach zero without end_signal
    run_case(3, 4'b1000, 1'b0, 4'hF, -1, 1'b0);
    check("lit_allzero_status", 32'(bus.status), 32'd2);
    check("lit_allzero_winner", 32'(bus.winner), 32'd0);

    // reset in the third RUN cycle, then restart on the first edge after
    run_case(100, 4'b0000, 1'b0, 4'b0000, 2, 1'b0);
    check("lit_rst_en",   32'(bus.PU_en),      32'd0);
    check("lit_rst_iter", 32'(bus.iter_count), 32'd0);
    run_case(1, 4'b0000, 1'b1, 4'b0111, -1, 1'b0);
    check("lit_after_rst_winner", 32'(bus.winner),     32'd3);
    check("lit_after_rst_iter",   32'(bus.iter_count), 32'd1);

    // end_signal on the limit cycle wins; start held through RUN/DONE
    run_case(10, 4'b1001, 1'b1, 4'b1011, -1, 1'b1);
    check("lit_simul_status", 32'(bus.status),     32'd0);
    check("lit_simul_winner", 32'(bus.winner),     32'd2);
    check("lit_simul_iter",   32'(bus.iter_count), 32'd10);

    // immediate end on the first RUN cycle
    run_case(0, 4'b0000, 1'b1, 4'b1101, -1, 1'b0);
    check("lit_first_winner", 32'(bus.winner),     32'd1);
    check("lit_first_iter",   32'(bus.iter_count), 32'd0);
    tick();
    tick();

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elim_controller.md
ELIM_CONTROLLER -- requirements
Module: elim_controller

Interface
REQ-001 SHALL have parameter MAX_ITER, default 255, meaning RUN-cycle limit before timeout (1..255).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a run, sampled in IDLE only.
REQ-005 SHALL have port end_signal  input  1  from end-signal generator, high when exactly one PU is nonzero.
REQ-006 SHALL have ports PU0_zero, PU1_zero, PU2_zero, PU3_zero  input  1 each  per-PU zero flags.
REQ-007 SHALL have port PU_load  output  1  load-initial-value strobe to all four PUs.
REQ-008 SHALL have port PU_en  output  1  iterate enable to all four PUs.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port winner  output  2  index of the sole nonzero PU, valid from done until next start.
REQ-011 SHALL have port status  output  2  result code: 00 ok, 01 timeout, 10 all_zero, 11 unused.
REQ-012 SHALL have port iter_count  output  8  number of RUN cycles of the current/last run.
REQ-013 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-014 SHALL implement states IDLE, LOAD, RUN, DONE, Moore outputs decoded from state register.
REQ-015 IDLE: start=1 -> LOAD next cycle; otherwise stay; start in any other state SHALL be ignored.
REQ-016 LOAD: PU_load=1 for exactly one cycle; iter_count, winner, status cleared to 0; -> RUN unconditionally.
REQ-017 RUN: PU_en=1; end_signal, zero flags ignored in LOAD and first RUN cycle's sampling is the flags after load.
REQ-018 RUN, end_signal=1 -> DONE; status=00; winner = index of the PU whose zero flag is 0.
REQ-019 RUN, all four zero flags=1 and end_signal=0 -> DONE; status=10; winner=00.
REQ-020 RUN, iter_count = MAX_ITER and neither REQ-018 nor REQ-019 holds -> DONE; status=01; winner=00.
REQ-021 Priority in the same cycle SHALL be end_signal > all_zero > timeout.
REQ-022 iter_count SHALL increment by 1 on each RUN cycle that does not exit, saturating at MAX_ITER, never wrapping.
REQ-023 PU_en SHALL be 0 in the exit cycle's successor (DONE); PUs receive no enable after end detection.
REQ-024 DONE: done=1 for one cycle; -> IDLE; winner, status, iter_count hold until next LOAD.
REQ-025 Latency: start sampled at edge N -> PU_load high N+1 -> PU_en high from N+2; done rises one cycle after the exit-condition edge.
REQ-026 end_signal SHALL be treated as synchronous to clk; no internal synchronizer.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, PU_load=0, PU_en=0, done=0, winner=00, status=00, iter_count=0, in any state including mid-RUN.
REQ-028 rst SHALL take precedence over start and all exit conditions in the same cycle.
REQ-029 After rst deasserts, start SHALL be accepted on the first following edge.

Structure
REQ-030 State encoding and status codes (OK, TIMEOUT, ALL_ZERO) SHALL live in shared package elim_pkg.
REQ-031 Winner encoding SHALL be a sub-module zero_encoder (4 zero flags -> 2-bit index of the single 0 flag, 00 otherwise).
REQ-032 Single flat FSM plus counter otherwise; no other sub-modules.

Verification
REQ-033 Normal: start, PU flags 1110 (PU0 nonzero only) after 5 RUN cycles -> done pulse, winner=00, status=00, iter_count=5.
REQ-034 Winner index: end_signal with PU2_zero=0, others 1 -> winner=10, status=00.
REQ-035 Timeout: MAX_ITER=10, end_signal held 0, flags mixed -> done after 10 RUN cycles, status=01, iter_count=10.
REQ-036 All zero: flags go 1111 with end_signal=0 -> done, status=10, winner=00.
REQ-037 Reset mid-RUN: rst at 3rd RUN cycle -> next cycle PU_en=0, iter_count=0, IDLE; start next cycle runs normally.
REQ-038 Simultaneous: end_signal=1 on cycle iter_count=MAX_ITER -> status=00; start held high during RUN/DONE -> no restart until IDLE.
